// File: rtl/approx_add_pkg.sv
// Shared definitions for the pipelined approximate adder.
// Holds the mode encoding and the lower-part-OR approximate sum function.
// The function works on a MAX_W-bit container. Callers zero-extend their
// operands into it and truncate the (MAX_W+1)-bit result to their own width.
package approx_add_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // Widest operand the helper function supports.
    localparam int unsigned MAX_W = 32;

    typedef logic [MAX_W:0] wide_sum_t;

    // Lower-part-OR adder. The low k bits are OR-ed. The upper part is an
    // exact add whose carry-in is a[k-1] & b[k-1]. k = 0 gives the exact sum.
    function automatic wide_sum_t approx_sum(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int unsigned      k
    );
        wide_sum_t a_w;
        wide_sum_t b_w;
        wide_sum_t lo_mask;
        wide_sum_t cin_w;
        wide_sum_t hi;
        a_w = wide_sum_t'(a);
        b_w = wide_sum_t'(b);
        if (k == 0) begin
            lo_mask = '0;
            cin_w   = '0;
        end else begin
            lo_mask = (wide_sum_t'(1) << k) - wide_sum_t'(1);
            // Bit k-1 of a&b, placed at weight 2^k as the upper carry-in.
            cin_w   = (((a_w & b_w) >> (k - 1)) & wide_sum_t'(1)) << k;
        end
        // Operands are zero above the caller's width, so the carry-out lands
        // in bit WIDTH of the caller's result.
        hi = (a_w & ~lo_mask) + (b_w & ~lo_mask) + cin_w;
        return hi | ((a_w | b_w) & lo_mask);
    endfunction

endpackage

// File: rtl/approx_add_core.sv
// Combinational core of the approximate adder.
// It computes both the approximate sum and the exact sum, and returns the
// selected result together with the error against the exact sum.
// Ports:
//   a_i, b_i      operands (WIDTH bits)
//   mode_i        MODE_EXACT / MODE_APPROX
//   sum_c_o       selected sum (WIDTH+1 bits)
//   err_c_o       selected sum differs from the exact sum
//   abs_err_c_o   |approx - exact|; 0 in exact mode
module approx_add_core
    import approx_add_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_BITS = 3
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mode_i,
    output logic [WIDTH:0]   sum_c_o,
    output logic             err_c_o,
    output logic [WIDTH:0]   abs_err_c_o
);

    localparam int unsigned SW = WIDTH + 1;

    logic [WIDTH:0] exact_c;
    logic [WIDTH:0] approx_c;

    assign exact_c  = SW'(a_i) + SW'(b_i);
    assign approx_c = SW'(approx_sum(MAX_W'(a_i), MAX_W'(b_i), APPROX_BITS));

    // The approximation can land on either side of the exact sum.
    always_comb begin
        sum_c_o     = exact_c;
        abs_err_c_o = '0;
        if (mode_i == MODE_APPROX) begin
            sum_c_o = approx_c;
            if (approx_c >= exact_c) begin
                abs_err_c_o = approx_c - exact_c;
            end else begin
                abs_err_c_o = exact_c - approx_c;
            end
        end
    end

    assign err_c_o = (abs_err_c_o != '0);

endmodule

// File: rtl/approx_adder_pipe.sv
// Two-stage pipelined approximate adder with a valid/ready stream interface
// and an in-line error statistics monitor.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         operand handshake (in_ready is combinational
//                             from out_ready only)
//   in_a, in_b, in_mode       operands and exact/approx select
//   out_valid/out_ready       result handshake
//   out_sum, out_err          result and "differs from exact" flag
//   clr_stats                 synchronous clear of the statistics
//   stat_total, stat_errs     delivered results / delivered with error (saturating)
//   stat_acc                  sum of absolute errors (saturating)
//   stat_max                  largest absolute error seen
module approx_adder_pipe
    import approx_add_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_BITS = 3,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned ACC_W       = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_err,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] stat_total,
    output logic [CNT_W-1:0] stat_errs,
    output logic [ACC_W-1:0] stat_acc,
    output logic [WIDTH:0]   stat_max
);

    localparam int unsigned AW1 = ACC_W + 1;

    // Stage 1: registered operands
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_mode_q, s1_mode_d;

    // Stage 2: registered result
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH:0]   s2_sum_q, s2_sum_d;
    logic             s2_err_q, s2_err_d;
    logic [WIDTH:0]   s2_abs_q, s2_abs_d;

    // Statistics
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] errs_q, errs_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH:0]   max_q, max_d;

    logic             s1_load_c;
    logic             s2_load_c;
    logic             xfer_c;
    logic [ACC_W:0]   acc_sum_c;
    logic [WIDTH:0]   core_sum_c;
    logic             core_err_c;
    logic [WIDTH:0]   core_abs_c;

    approx_add_core #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_core (
        .a_i         (s1_a_q),
        .b_i         (s1_b_q),
        .mode_i      (s1_mode_q),
        .sum_c_o     (core_sum_c),
        .err_c_o     (core_err_c),
        .abs_err_c_o (core_abs_c)
    );

    // Next-state for pipeline and statistics
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_err_d   = s2_err_q;
        s2_abs_d   = s2_abs_q;
        total_d    = total_q;
        errs_d     = errs_q;
        acc_d      = acc_q;
        max_d      = max_q;

        s2_load_c  = !s2_valid_q || out_ready;
        s1_load_c  = !s1_valid_q || s2_load_c;
        xfer_c     = s2_valid_q && out_ready;
        acc_sum_c  = AW1'(acc_q) + AW1'(s2_abs_q);

        if (s2_load_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_d = core_sum_c;
                s2_err_d = core_err_c;
                s2_abs_d = core_abs_c;
            end
        end

        if (s1_load_c) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d    = in_a;
                s1_b_d    = in_b;
                s1_mode_d = in_mode;
            end
        end

        // A clear takes priority over a coincident output transfer.
        if (clr_stats) begin
            total_d = '0;
            errs_d  = '0;
            acc_d   = '0;
            max_d   = '0;
        end else if (xfer_c) begin
            if (total_q != '1) begin
                total_d = total_q + CNT_W'(1);
            end
            if (s2_err_q && (errs_q != '1)) begin
                errs_d = errs_q + CNT_W'(1);
            end
            acc_d = acc_sum_c[ACC_W] ? '1 : acc_sum_c[ACC_W-1:0];
            if (s2_abs_q > max_q) begin
                max_d = s2_abs_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= MODE_EXACT;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_err_q   <= 1'b0;
            s2_abs_q   <= '0;
            total_q    <= '0;
            errs_q     <= '0;
            acc_q      <= '0;
            max_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_err_q   <= s2_err_d;
            s2_abs_q   <= s2_abs_d;
            total_q    <= total_d;
            errs_q     <= errs_d;
            acc_q      <= acc_d;
            max_q      <= max_d;
        end
    end

    // in_ready depends only on pipeline occupancy and out_ready.
    assign in_ready   = s1_load_c;
    assign out_valid  = s2_valid_q;
    assign out_sum    = s2_sum_q;
    assign out_err    = s2_err_q;
    assign stat_total = total_q;
    assign stat_errs  = errs_q;
    assign stat_acc   = acc_q;
    assign stat_max   = max_q;

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Self-checking bench for approx_adder_pipe (WIDTH=8, APPROX_BITS=3).
module tb_approx_adder_pipe;

    localparam int WIDTH = 8;
    localparam int K     = 3;
    localparam int CNT_W = 16;
    localparam int ACC_W = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic             out_err;
    logic             clr_stats;
    logic [CNT_W-1:0] stat_total;
    logic [CNT_W-1:0] stat_errs;
    logic [ACC_W-1:0] stat_acc;
    logic [WIDTH:0]   stat_max;

    approx_adder_pipe #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (K),
        .CNT_W       (CNT_W),
        .ACC_W       (ACC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_err    (out_err),
        .clr_stats  (clr_stats),
        .stat_total (stat_total),
        .stat_errs  (stat_errs),
        .stat_acc   (stat_acc),
        .stat_max   (stat_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       mode;
        logic [8:0] sum;
        logic       err;
    } vec_t;

    vec_t vt[10];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Ripple-carry reference: OR on the low K bits, carry-in a[K-1]&b[K-1].
    function automatic logic [8:0] ref_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic mode);
        logic [8:0] s;
        logic       c;
        if (!mode) return {1'b0, a} + {1'b0, b};
        s = '0;
        for (int i = 0; i < K; i++) s[i] = a[i] | b[i];
        c = a[K-1] & b[K-1];
        for (int i = K; i < 8; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        s[8] = c;
        return s;
    endfunction

    // Operand patterns for the streaming sequences.
    function automatic logic [7:0] sa(input int i);
        return 8'((i + 1) * 19);
    endfunction
    function automatic logic [7:0] sb(input int i);
        return 8'(45 + i * 7);
    endfunction
    function automatic logic sm(input int i);
        return (i % 2) == 1;
    endfunction

    // Single transaction with out_ready=1; checks latency, sum and error flag.
    task automatic send_one(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = v.a;
        in_b      = v.b;
        in_mode   = v.mode;
        out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'(1));
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            #1;
        end while (!out_valid && lat < 20);
        check({tag, " latency"}, 32'(lat), 32'(2));
        check({tag, " sum"}, 32'(out_sum), 32'(v.sum));
        check({tag, " err"}, 32'(out_err), 32'(v.err));
    endtask

    initial begin
        int si;
        int ei;
        int stall_acc;

        vt[0] = '{8'h07, 8'h01, 1'b1, 9'h007, 1'b1};
        vt[1] = '{8'h07, 8'h01, 1'b0, 9'h008, 1'b0};
        vt[2] = '{8'h04, 8'h04, 1'b1, 9'h00C, 1'b1};
        vt[3] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b1};
        vt[4] = '{8'hFF, 8'hFF, 1'b0, 9'h1FE, 1'b0};
        vt[5] = '{8'h00, 8'h00, 1'b1, 9'h000, 1'b0};
        vt[6] = '{8'h10, 8'h20, 1'b1, 9'h030, 1'b0};
        vt[7] = '{8'h03, 8'h05, 1'b1, 9'h007, 1'b1};
        vt[8] = '{8'h80, 8'h80, 1'b1, 9'h100, 1'b0};
        vt[9] = '{8'h06, 8'h05, 1'b1, 9'h00F, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        clr_stats = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'(0));
        check("rst out_sum", 32'(out_sum), 32'(0));
        check("rst out_err", 32'(out_err), 32'(0));
        check("rst stat_total", 32'(stat_total), 32'(0));
        check("rst stat_acc", 32'(stat_acc), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'(1));

        // First four vectors, then statistics
        for (int i = 0; i < 4; i++) send_one(vt[i], $sformatf("vec%0d", i));
        @(negedge clk);
        #1;
        check("stats total", 32'(stat_total), 32'(4));
        check("stats errs", 32'(stat_errs), 32'(3));
        check("stats acc", 32'(stat_acc), 32'(6));
        check("stats max", 32'(stat_max), 32'(4));

        // Clear coinciding with an output transfer
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 8'h07;
        in_b     = 8'h01;
        in_mode  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("clr out_valid", 32'(out_valid), 32'(1));
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
        #1;
        check("clr out_valid after", 32'(out_valid), 32'(0));
        check("clr total", 32'(stat_total), 32'(0));
        check("clr errs", 32'(stat_errs), 32'(0));
        check("clr acc", 32'(stat_acc), 32'(0));
        check("clr max", 32'(stat_max), 32'(0));

        // Remaining table vectors and resulting statistics
        for (int i = 4; i < 10; i++) send_one(vt[i], $sformatf("vec%0d", i));
        @(negedge clk);
        #1;
        check("stats2 total", 32'(stat_total), 32'(6));
        check("stats2 errs", 32'(stat_errs), 32'(2));
        check("stats2 acc", 32'(stat_acc), 32'(5));
        check("stats2 max", 32'(stat_max), 32'(4));

        // Eight back-to-back transactions at full throughput
        out_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (t < 8) begin
                in_valid = 1'b1;
                in_a     = sa(t);
                in_b     = sb(t);
                in_mode  = sm(t);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (t < 8) check($sformatf("stream in_ready t%0d", t), 32'(in_ready), 32'(1));
            check($sformatf("stream out_valid t%0d", t), 32'(out_valid),
                  32'(t >= 2 && t < 10));
            if (t >= 2 && t < 10)
                check($sformatf("stream sum t%0d", t), 32'(out_sum),
                      32'(ref_sum(sa(t - 2), sb(t - 2), sm(t - 2))));
            @(negedge clk);
        end

        // Backpressure: out_ready low for the first 5 cycles
        si        = 8;
        ei        = 8;
        stall_acc = 0;
        for (int t = 0; t < 40 && ei < 16; t++) begin
            out_ready = (t >= 5);
            in_valid  = (si < 16);
            in_a      = sa(si);
            in_b      = sb(si);
            in_mode   = sm(si);
            #1;
            if (t >= 2 && t < 5) begin
                check($sformatf("bp in_ready t%0d", t), 32'(in_ready), 32'(0));
                check($sformatf("bp hold valid t%0d", t), 32'(out_valid), 32'(1));
                check($sformatf("bp hold sum t%0d", t), 32'(out_sum),
                      32'(ref_sum(sa(8), sb(8), sm(8))));
            end
            if (out_valid) begin
                check($sformatf("bp sum idx%0d", ei), 32'(out_sum),
                      32'(ref_sum(sa(ei), sb(ei), sm(ei))));
                if (out_ready) ei++;
            end
            if (in_valid && in_ready) begin
                si++;
                if (t < 5) stall_acc++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp delivered", 32'(ei), 32'(16));
        check("bp accepts during stall", 32'(stall_acc), 32'(2));
        repeat (3) @(negedge clk);
        #1;
        check("bp no extra output", 32'(out_valid), 32'(0));
        check("bp stats total", 32'(stat_total), 32'(22));

        // Reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'h33;
        in_b      = 8'h44;
        in_mode   = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full in_ready", 32'(in_ready), 32'(0));
        check("full out_valid", 32'(out_valid), 32'(1));
        rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'(0));
        check("async rst total", 32'(stat_total), 32'(0));
        check("async rst errs", 32'(stat_errs), 32'(0));
        check("async rst acc", 32'(stat_acc), 32'(0));
        check("async rst max", 32'(stat_max), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        send_one(vt[9], "after-rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
